mor1kx_rf_wb_arbiter: RTL

// - Owns the single write port of the espresso register file; shares it between ALU writeback, LSU load return and debug unit.
// - Sequences post-reset zero-fill of all RF words; RAM contents are not reset.
// - Sits between control stage/LSU/debug and the RF write inputs (we, waddr, din).

---
 rtl/mor1kx_rf_wb_arbiter_pkg.sv | 15 +
 rtl/mor1kx_rf_wb_skid.sv | 51 +++++
 rtl/mor1kx_rf_wb_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mor1kx_rf_wb_arbiter_pkg.sv
// Shared types and helpers for the register-file writeback arbiter.
// FSM state encoding and starve-counter sizing live here.
package mor1kx_rf_wb_arbiter_pkg;

  typedef enum logic [0:0] {
    RfArbInit = 1'b0,
    RfArbRun  = 1'b1
  } rf_arb_state_e;

  // Counter must hold the saturation value itself.
  function automatic int unsigned starve_cnt_width(input int unsigned max_cnt);
    return $clog2(max_cnt + 1);
  endfunction

endpackage

// File: rtl/mor1kx_rf_wb_skid.sv
// One-entry buffer for a load beat that lost the RF write port to the ALU.
// A later ALU write to the same GPR kills the entry so older load data never lands.
module mor1kx_rf_wb_skid #(
  parameter int unsigned AW = 5,
  parameter int unsigned OW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [AW-1:0] load_adr_i,
  input  logic [OW-1:0] load_dat_i,
  input  logic          drain_i,
  input  logic          kill_i,
  input  logic [AW-1:0] kill_adr_i,
  output logic          valid_o,
  output logic [AW-1:0] adr_o,
  output logic [OW-1:0] dat_o
);

  logic          valid_q, valid_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [OW-1:0] dat_q, dat_d;

  always_comb begin
    valid_d = valid_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    if (load_i) begin
      valid_d = 1'b1;
      adr_d   = load_adr_i;
      dat_d   = load_dat_i;
    end else if (drain_i || (kill_i && (adr_q == kill_adr_i))) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
    adr_q <= adr_d;
    dat_q <= dat_d;
  end

  assign valid_o = valid_q;
  assign adr_o   = adr_q;
  assign dat_o   = dat_q;

endmodule

// File: rtl/mor1kx_rf_wb_arbiter.sv
// Owns the RF write port: ALU > skid > direct load > debug, plus optional zero-fill.
// Zero-fill after reset is built only when MOR1KX_RF_INIT_EN is defined.
module mor1kx_rf_wb_arbiter
  import mor1kx_rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned OPTION_RF_ADDR_WIDTH = 5,
  parameter int unsigned OPTION_RF_WORDS      = 32,
  parameter int unsigned OPTION_OPERAND_WIDTH = 32,
  parameter int unsigned DBG_STARVE_MAX       = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            alu_we_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] alu_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] alu_dat_i,
  input  logic                            lsu_valid_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] lsu_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] lsu_dat_i,
  output logic                            lsu_ready_o,
  input  logic                            dbg_req_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] dbg_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] dbg_dat_i,
  output logic                            dbg_ack_o,
  output logic                            stall_o,
  output logic                            init_busy_o,
  output logic                            rf_we_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0] rf_adr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] rf_dat_o
);

  localparam int unsigned AW  = OPTION_RF_ADDR_WIDTH;
  localparam int unsigned OW  = OPTION_OPERAND_WIDTH;
  localparam int unsigned SCW = starve_cnt_width(DBG_STARVE_MAX);

  if (OPTION_RF_WORDS < 1 || OPTION_RF_WORDS > (1 << OPTION_RF_ADDR_WIDTH)) begin : g_bad_words
    $error("OPTION_RF_WORDS does not fit OPTION_RF_ADDR_WIDTH");
  end

  rf_arb_state_e state_q;
  logic [AW-1:0] init_adr;
  logic          in_init;

`ifdef MOR1KX_RF_INIT_EN
  localparam logic InitEn = 1'b1;

  rf_arb_state_e state_d;
  logic [AW-1:0] init_cnt_q, init_cnt_d;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == RfArbInit) begin
      init_cnt_d = init_cnt_q + AW'(1);
      if (init_cnt_q == AW'(OPTION_RF_WORDS - 1)) begin
        state_d = RfArbRun;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RfArbInit;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  assign init_adr = init_cnt_q;
`else
  localparam logic InitEn = 1'b0;

  assign state_q  = RfArbRun;
  assign init_adr = '0;
`endif

  assign in_init = (state_q == RfArbInit);

  logic          run;
  logic          lsu_ready;
  logic          lsu_acc;
  logic          alu_wr;
  logic          skid_load;
  logic          skid_drain;
  logic          skid_valid;
  logic [AW-1:0] skid_adr;
  logic [OW-1:0] skid_dat;
  logic          dbg_grant;
  logic          dbg_starved;
  logic [SCW-1:0] starve_q, starve_d;

  assign run       = !rst && !in_init;
  assign lsu_ready = run && !skid_valid;
  assign lsu_acc   = lsu_valid_i && lsu_ready;
  assign alu_wr    = run && alu_we_i;
  // A load beat to the GPR the ALU writes this cycle is older, so it is dropped.
  assign skid_load  = lsu_acc && alu_wr && (lsu_adr_i != alu_adr_i);
  assign skid_drain = run && skid_valid && !alu_we_i;
  assign dbg_grant  = run && dbg_req_i && !alu_we_i && !skid_valid && !lsu_acc;

  mor1kx_rf_wb_skid #(
    .AW(AW),
    .OW(OW)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .load_i     (skid_load),
    .load_adr_i (lsu_adr_i),
    .load_dat_i (lsu_dat_i),
    .drain_i    (skid_drain),
    .kill_i     (alu_wr),
    .kill_adr_i (alu_adr_i),
    .valid_o    (skid_valid),
    .adr_o      (skid_adr),
    .dat_o      (skid_dat)
  );

  assign dbg_starved = (starve_q == SCW'(DBG_STARVE_MAX));

  always_comb begin
    starve_d = starve_q;
    if (!dbg_req_i || dbg_grant) begin
      starve_d = '0;
    end else if (run && !dbg_starved) begin
      starve_d = starve_q + SCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  always_comb begin
    rf_we_o  = 1'b0;
    rf_adr_o = '0;
    rf_dat_o = '0;
    if (!rst && in_init) begin
      rf_we_o  = 1'b1;
      rf_adr_o = init_adr;
    end else if (alu_wr) begin
      rf_we_o  = 1'b1;
      rf_adr_o = alu_adr_i;
      rf_dat_o = alu_dat_i;
    end else if (skid_drain) begin
      rf_we_o  = 1'b1;
      rf_adr_o = skid_adr;
      rf_dat_o = skid_dat;
    end else if (lsu_acc) begin
      rf_we_o  = 1'b1;
      rf_adr_o = lsu_adr_i;
      rf_dat_o = lsu_dat_i;
    end else if (dbg_grant) begin
      rf_we_o  = 1'b1;
      rf_adr_o = dbg_adr_i;
      rf_dat_o = dbg_dat_i;
    end
  end

  assign lsu_ready_o = lsu_ready;
  assign dbg_ack_o   = dbg_grant;
  assign stall_o     = rst ? InitEn : (in_init || skid_valid || dbg_starved);
  assign init_busy_o = rst ? InitEn : in_init;

endmodule
